// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART transmitter.
// Contents: shift-engine state enum, status word bit positions, frame size.
package servant_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_BUSY    = 1;
  localparam int unsigned STAT_CNT_LSB = 4;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BYTE_W    = 8;

endpackage

// File: rtl/servant_uart_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, din     enqueue request and byte; accepted when not full or popping
//   pop           dequeue request; ignored when empty
//   head_c        byte at the read pointer (combinational)
//   full_c        count == depth (combinational)
//   empty_c       count == 0 (combinational)
//   count         registered occupancy, 0..2**AW
module servant_uart_fifo
  import servant_uart_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] head_c,
  output logic              full_c,
  output logic              empty_c,
  output logic [AW:0]       count
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CNT_W = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    empty_c = (count == '0);
    full_c  = (count == CNT_W'(DEPTH));
    do_pop  = pop & ~empty_c;
    do_push = push & (~full_c | do_pop);
    head_c  = mem[rd_ptr];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at 2**AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/servant_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter for the servant peripheral bus.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_wb_cyc  access strobe, high for two cycles per access
//   i_wb_we   1 = enqueue i_wb_dat[7:0], 0 = status read
//   i_wb_dat  write data (bits 31:8 ignored)
//   o_wb_dat  registered status: [0] full, [1] busy, [FIFO_AW+4:4] count
//   o_tx      serial output, idle high
module servant_uart_tx
  import servant_uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 139,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_tx
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned CNT_W  = FIFO_AW + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_t       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              cyc_q;

  logic              push_c;
  logic              pop_c;
  logic              baud_done_c;
  logic [BYTE_W-1:0] head_c;
  logic              full_c;
  logic              empty_c;
  logic [CNT_W-1:0]  count;
  logic [31:0]       status_c;
  logic              unused_dat_c;

  assign unused_dat_c = ^i_wb_dat[31:BYTE_W];

  servant_uart_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (i_wb_dat[BYTE_W-1:0]),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (count)
  );

  // Only the first cycle of an access counts, so each write pushes once.
  // Pops happen from IDLE, or at the end of STOP to chain frames gap-free.
  always_comb begin
    push_c      = i_wb_cyc & ~cyc_q & i_wb_we;
    baud_done_c = (baud_cnt == '0);
    pop_c       = 1'b0;
    if (!empty_c) begin
      case (state)
        IDLE:    pop_c = 1'b1;
        STOP:    pop_c = baud_done_c;
        default: pop_c = 1'b0;
      endcase
    end
    status_c                           = '0;
    status_c[STAT_FULL]                = full_c;
    status_c[STAT_BUSY]                = (state != IDLE) | ~empty_c;
    status_c[STAT_CNT_LSB +: CNT_W]    = count;
  end

  // Shift engine: o_tx is registered and changes together with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cyc_q    <= 1'b0;
      o_tx     <= 1'b1;
      o_wb_dat <= '0;
    end else begin
      cyc_q    <= i_wb_cyc;
      o_wb_dat <= status_c;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (pop_c) begin
            shreg    <= head_c;
            baud_cnt <= BAUD_LAST;
            o_tx     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done_c) begin
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            o_tx     <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done_c) begin
            baud_cnt <= BAUD_LAST;
            if (bit_cnt == BIT_LAST) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[BYTE_W-1:1]};
              o_tx    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_done_c) begin
            if (pop_c) begin
              shreg    <= head_c;
              baud_cnt <= BAUD_LAST;
              o_tx     <= 1'b0;
              state    <= START;
            end else begin
              o_tx  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_uart_tx.sv
// Testbench for servant_uart_tx (DIVISOR=4, FIFO_AW=2).
// Writes push expected bytes into a queue; a serial monitor decodes frames
// on o_tx and pops/compares them. Status and timing are checked inline.
module tb_servant_uart_tx;

  localparam int unsigned DIV = 4;
  localparam int unsigned AW  = 2;
  localparam int unsigned FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        we;
  logic [31:0] dat;
  logic [31:0] rdat;
  logic        tx;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  servant_uart_tx #(
    .DIVISOR (DIV),
    .FIFO_AW (AW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_cyc (cyc),
    .i_wb_we  (we),
    .i_wb_dat (dat),
    .o_wb_dat (rdat),
    .o_tx     (tx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One bus access: cyc high for two cycles, then one idle cycle.
  task automatic access(input logic w, input logic [31:0] d, input logic accept);
    if (w && accept) exp_q.push_back(d[7:0]);
    cyc = 1'b1;
    we  = w;
    dat = d;
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0;
    we  = 1'b0;
    dat = '0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((rdat[1] !== 1'b0 || tx !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(n < budget), 32'd1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Serial monitor: every sample of each bit period must match the frame.
  always begin
    logic [7:0] exp_b;
    logic [7:0] rx;
    logic [9:0] frame;
    logic       bad;
    logic       aborted;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
        repeat (FRAME) @(negedge clk);
      end else begin
        exp_b = exp_q.pop_front();
        start_q.push_back(cyc_n);
        frame   = {1'b1, exp_b, 1'b0};
        bad     = 1'b0;
        aborted = 1'b0;
        rx      = '0;
        for (int s = 0; s < int'(FRAME); s++) begin
          if (s > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== frame[s / int'(DIV)]) bad = 1'b1;
          if (s >= int'(DIV) && s < int'(9 * DIV) && (s % int'(DIV)) == int'(DIV / 2))
            rx[s / int'(DIV) - 1] = tx;
        end
        if (!aborted) begin
          chk("frame_data", 32'(rx), 32'(exp_b));
          chk("frame_shape", 32'(bad), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet_bad;
    rst = 1'b1;
    cyc = 1'b0;
    we  = 1'b0;
    dat = '0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_stat", rdat, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_stat", rdat, 32'd0);

    // Single write 0xA5: latency and busy timing
    exp_q.push_back(8'hA5);
    cyc = 1'b1;
    we  = 1'b1;
    dat = 32'h0000_00A5;
    @(negedge clk);
    chk("lat_n1_tx", 32'(tx), 32'd1);
    @(negedge clk);
    chk("lat_n2_tx", 32'(tx), 32'd0);
    chk("stat_after_push", rdat, 32'h12);
    cyc = 1'b0;
    we  = 1'b0;
    dat = '0;
    repeat (FRAME) @(negedge clk);
    chk("busy_stop_end", rdat, 32'h2);
    @(negedge clk);
    chk("busy_clear", rdat, 32'h0);
    chk("a5_drained", 32'(exp_q.size()), 32'd0);

    // Read has no side effects
    access(1'b0, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(negedge clk);
    chk("read_stat", rdat, 32'h0);
    chk("read_tx", 32'(tx), 32'd1);

    // Back-to-back 0x00 then 0xFF, upper data bits ignored
    start_q.delete();
    access(1'b1, 32'hFFFF_FF00, 1'b1);
    access(1'b1, 32'h1234_56FF, 1'b1);
    wait_idle(300);
    chk("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2)
      chk("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

    // Fill: 0x01 transmits, 0x02..0x05 fill, 0x06 dropped
    for (int i = 1; i <= 6; i++) access(1'b1, 32'(i), i <= 5);
    chk("full_stat", rdat, 32'h43);
    wait_idle(600);

    // Write to full FIFO on the STOP-end pop cycle
    access(1'b1, 32'h11, 1'b1);
    for (int i = 'h12; i <= 'h15; i++) access(1'b1, 32'(i), 1'b1);
    repeat (26) @(negedge clk);
    chk("pre_simul_stat", rdat, 32'h43);
    access(1'b1, 32'h16, 1'b1);
    chk("simul_stat", rdat, 32'h43);
    wait_idle(600);

    // Reset during DATA bit 3 of 0x3C with two bytes queued
    access(1'b1, 32'h3C, 1'b1);
    access(1'b1, 32'h3D, 1'b1);
    access(1'b1, 32'h3E, 1'b1);
    repeat (10) @(negedge clk);
    chk("pre_rst_stat", rdat, 32'h22);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_stat", rdat, 32'h0);
    quiet_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdat !== 32'h0) quiet_bad = 1'b1;
    end
    chk("rst_quiet", 32'(quiet_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
